// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - AHB-Lite encodings and slave FSM state shared by the DMAC subsystem
package dmac_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  localparam int WAIT_CNT_W = 4;

  // Unsupported size or an address not aligned to the transfer size.
  function automatic logic size_error(input logic [1:0] size, input logic [1:0] lsb);
    logic err;
    err = 1'b0;
    if (size == 2'b11) err = 1'b1;
    else if (size == SIZE_HALF && lsb[0]) err = 1'b1;
    else if (size == SIZE_WORD && lsb != 2'b00) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// rtl/ahb_sram_bank.sv - word SRAM with byte-lane synchronous write and asynchronous read
module ahb_sram_bank #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite responder over a word SRAM with wait states and ERROR responses
module ahb_slave_mem
  import dmac_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [1:0]  HSize,
  input  logic [3:0]  HWStrb,
  input  logic [31:0] HWData,
  output logic        HReady,
  output logic [1:0]  HResp,
  output logic [31:0] HRData
);

  localparam int                    IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [32:0]           WINDOW_BYTES = 33'(4 * DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  slv_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;

  logic [31:0] offset;
  logic [31:0] mem_rdata;
  logic [3:0]  lane_we;
  logic        capture;
  logic        out_of_range;
  logic        access_err;

  assign offset       = HAddr - BASE_ADDR;
  assign out_of_range = (HAddr < BASE_ADDR) || ({1'b0, offset} >= WINDOW_BYTES);
  assign access_err   = out_of_range || size_error(HSize, HAddr[1:0]);
  assign capture      = HSel && HReady &&
                        (HTrans == TRANS_NONSEQ || HTrans == TRANS_SEQ);

  assign HReady = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign HResp  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
  assign HRData = (state_q == ST_DATA && !write_q) ? mem_rdata : 32'h0;

  // Gating on rst keeps a reset that lands on a write data phase from committing it.
  assign lane_we = (rst && state_q == ST_DATA && write_q) ? HWStrb : 4'b0000;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == '0) state_d = ST_DATA;
        else wait_cnt_d = wait_cnt_q - 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all accept the pipelined next address phase.
        state_d = ST_IDLE;
        if (capture) begin
          if (access_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (capture) begin
        idx_q   <= offset[IDX_W+1:2];
        write_q <= HWrite;
      end
    end
  end

  ahb_sram_bank #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk   (clk),
    .addr  (idx_q),
    .we    (lane_we),
    .wdata (HWData),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem at zero and two wait states
module tb_ahb_slave_mem;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  eresp;
    logic [31:0] erdata;
    int          ewaits;
  } item_t;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [1:0]  hsize;
  logic [3:0]  hwstrb;
  logic [31:0] hwdata;
  bit          dsel;

  logic        hready0, hready2, hready;
  logic [1:0]  hresp0, hresp2, hresp;
  logic [31:0] hrdata0, hrdata2, hrdata;
  logic        hsel0, hsel2;

  int checks = 0;
  int errors = 0;

  item_t       pend[$];
  item_t       sb[$];
  logic [31:0] mdl [2][256];

  assign hsel0  = hsel && !dsel;
  assign hsel2  = hsel && dsel;
  assign hready = dsel ? hready2 : hready0;
  assign hresp  = dsel ? hresp2 : hresp0;
  assign hrdata = dsel ? hrdata2 : hrdata0;

  ahb_slave_mem #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .HSel(hsel0), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HWStrb(hwstrb), .HWData(hwdata),
    .HReady(hready0), .HResp(hresp0), .HRData(hrdata0)
  );

  ahb_slave_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .HSel(hsel2), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HWStrb(hwstrb), .HWData(hwdata),
    .HReady(hready2), .HResp(hresp2), .HRData(hrdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                     input logic [1:0] size, input logic [3:0] strb, input logic [31:0] wdata);
    item_t it;
    it.trans = trans; it.wr = wr; it.addr = addr; it.size = size;
    it.strb = strb; it.wdata = wdata;
    it.eresp = 2'b00; it.erdata = 32'h0; it.ewaits = 0;
    pend.push_back(it);
  endtask

  // Expected response for an accepted address phase; writes update the reference memory.
  task automatic score(input item_t it);
    logic [31:0] base;
    logic [31:0] off;
    logic        err;
    int          idx;
    base = dsel ? 32'h0000_1000 : 32'h0000_0000;
    if (it.trans == 2'b10 || it.trans == 2'b11) begin
      off = it.addr - base;
      err = (it.addr < base) || (off >= 32'h400) || (it.size == 2'b11) ||
            (it.size == 2'b01 && it.addr[0]) || (it.size == 2'b10 && it.addr[1:0] != 2'b00);
      if (err) begin
        it.eresp  = 2'b01;
        it.ewaits = 1;
      end else begin
        idx       = int'(off[9:2]);
        it.ewaits = dsel ? 2 : 0;
        if (it.wr) begin
          for (int b = 0; b < 4; b++)
            if (it.strb[b]) mdl[dsel][idx][8*b +: 8] = it.wdata[8*b +: 8];
        end else begin
          it.erdata = mdl[dsel][idx];
        end
      end
    end
    sb.push_back(it);
  endtask

  // Pipelined master: one loop iteration per clock, inputs driven #1 after posedge, outputs sampled at negedge.
  task automatic run(output int cycles);
    item_t dp;
    item_t e;
    bit    dp_v;
    bit    rdy;
    int    lows;
    dp_v = 1'b0; lows = 0; cycles = 0;
    while ((pend.size() > 0 || dp_v) && cycles < 100) begin
      if (pend.size() > 0) begin
        hsel = 1'b1; htrans = pend[0].trans; haddr = pend[0].addr;
        hwrite = pend[0].wr; hsize = pend[0].size;
      end else begin
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 2'b00;
      end
      hwstrb = dp_v ? dp.strb : 4'h0;
      hwdata = dp_v ? dp.wdata : 32'h0;
      @(negedge clk);
      rdy = hready;
      if (dp_v && !rdy) begin
        lows++;
        chk("hresp_during_stall", 32'(hresp), (sb.size() > 0) ? 32'(sb[0].eresp) : 32'hffff_ffff);
      end else if (dp_v) begin
        e = sb.pop_front();
        chk("hresp", 32'(hresp), 32'(e.eresp));
        chk("hrdata", hrdata, e.erdata);
        chk("stall_cycles", 32'(lows), 32'(e.ewaits));
      end
      @(posedge clk); #1;
      cycles++;
      if (rdy) begin
        dp_v = 1'b0;
        if (pend.size() > 0) begin
          dp = pend.pop_front();
          dp_v = 1'b1;
          lows = 0;
          score(dp);
        end
      end
    end
    chk("run_timeout_pending", 32'(pend.size()) + 32'(dp_v), 32'h0);
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 2'b00;
    hwstrb = 4'h0; hwdata = 32'h0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 2'b00; hwstrb = 4'h0; hwdata = 32'h0; dsel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      dsel = (d == 1);
      #1;
      chk("reset_hready", 32'(hready), 32'h1);
      chk("reset_hresp", 32'(hresp), 32'h0);
      chk("reset_hrdata", hrdata, 32'h0);
    end
    dsel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: basic write/read, byte strobes, halfword, top of window.
    add(2'b10, 1'b1, 32'h10, 2'b10, 4'hF, 32'hDEAD_BEEF);
    add(2'b10, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0);
    run(cyc);
    chk("basic_cycles", 32'(cyc), 32'd3);

    add(2'b10, 1'b1, 32'h20, 2'b10, 4'hF, 32'h1122_3344);
    add(2'b10, 1'b1, 32'h20, 2'b10, 4'b0100, 32'hAABB_CCDD);
    add(2'b10, 1'b0, 32'h20, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h20, 2'b10, 4'h0, 32'hFFFF_FFFF);
    add(2'b10, 1'b0, 32'h20, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h00, 2'b10, 4'hF, 32'h0102_0304);
    add(2'b10, 1'b1, 32'h02, 2'b01, 4'b1100, 32'hBEEF_0000);
    add(2'b10, 1'b0, 32'h00, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h03, 2'b00, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h3FC, 2'b10, 4'hF, 32'hCAFE_F00D);
    add(2'b10, 1'b0, 32'h3FC, 2'b10, 4'h0, 32'h0);
    run(cyc);

    // Error responses leave memory untouched, including no wrap of 0x400 onto word 0.
    add(2'b10, 1'b0, 32'h02, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h400, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h400, 2'b10, 4'hF, 32'h9999_9999);
    add(2'b10, 1'b1, 32'h12, 2'b10, 4'hF, 32'h8888_8888);
    add(2'b10, 1'b1, 32'h01, 2'b01, 4'hF, 32'h7777_7777);
    add(2'b10, 1'b0, 32'h00, 2'b11, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h00, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0);
    run(cyc);

    // Back-to-back bursts, read-after-write, IDLE inserted mid-burst.
    add(2'b10, 1'b1, 32'h40, 2'b10, 4'hF, 32'h4040_4040);
    add(2'b11, 1'b1, 32'h44, 2'b10, 4'hF, 32'h4444_4444);
    add(2'b11, 1'b1, 32'h48, 2'b10, 4'hF, 32'h4848_4848);
    add(2'b11, 1'b1, 32'h4C, 2'b10, 4'hF, 32'h4C4C_4C4C);
    run(cyc);
    chk("write_burst_cycles", 32'(cyc), 32'd5);
    add(2'b10, 1'b0, 32'h40, 2'b10, 4'h0, 32'h0);
    add(2'b11, 1'b0, 32'h44, 2'b10, 4'h0, 32'h0);
    add(2'b00, 1'b1, 32'h48, 2'b10, 4'hF, 32'hFFFF_FFFF);
    add(2'b11, 1'b0, 32'h48, 2'b10, 4'h0, 32'h0);
    add(2'b11, 1'b0, 32'h4C, 2'b10, 4'h0, 32'h0);
    run(cyc);
    chk("read_burst_cycles", 32'(cyc), 32'd6);
    add(2'b10, 1'b1, 32'h30, 2'b10, 4'hF, 32'h3030_ABCD);
    add(2'b10, 1'b0, 32'h30, 2'b10, 4'h0, 32'h0);
    add(2'b01, 1'b0, 32'h34, 2'b10, 4'h0, 32'h0);
    run(cyc);

    // Two wait states, window based at 0x1000.
    dsel = 1'b1;
    #1;
    add(2'b10, 1'b1, 32'h1004, 2'b10, 4'hF, 32'h0BAD_CAFE);
    add(2'b10, 1'b0, 32'h1004, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h0FFC, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b0, 32'h1400, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h13FC, 2'b10, 4'hF, 32'h1357_9BDF);
    add(2'b10, 1'b0, 32'h13FC, 2'b10, 4'h0, 32'h0);
    add(2'b10, 1'b1, 32'h1080, 2'b10, 4'hF, 32'h5555_AAAA);
    add(2'b10, 1'b0, 32'h1080, 2'b10, 4'h0, 32'h0);
    run(cyc);

    // Reset during a wait cycle of a write abandons it.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h1080; hwrite = 1'b1; hsize = 2'b10;
    hwstrb = 4'h0; hwdata = 32'h0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwstrb = 4'hF; hwdata = 32'hFFFF_FFFF; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_wait_hready", 32'(hready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; hwstrb = 4'h0; hwdata = 32'h0;
    @(negedge clk);
    chk("after_rst_hready", 32'(hready), 32'h1);
    chk("after_rst_hresp", 32'(hresp), 32'h0);
    chk("after_rst_hrdata", hrdata, 32'h0);
    @(posedge clk); #1;
    add(2'b10, 1'b0, 32'h1080, 2'b10, 4'h0, 32'h0);
    run(cyc);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
